// File: rtl/ieee_to_flopoco_conv_pkg.sv
// Shared constants and types for the IEEE minifloat to FloPoCo converter.
package flopoco_pkg;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef enum logic [2:0] {
        ZERO,
        NORMAL,
        SUBN,
        FLUSH,
        INF,
        NAN
    } fp_class_t;

    function automatic int fpc_width(input int we, input int wf);
        return 3 + we + wf;
    endfunction

endpackage

// File: rtl/ieee_to_flopoco_conv_if.sv
// Streaming bus of the converter: IEEE words in, FloPoCo words plus flush sideband out.
// Both sides use valid/ready: a word moves on a cycle where valid & ready, and a
// producer holding valid keeps its data stable and valid high until that happens.
interface ieee_to_flopoco_conv_if import flopoco_pkg::*; #(
    parameter int WE = 3,
    parameter int WF = 3
);
    logic                           in_valid;
    logic                           in_ready;
    logic [WE+WF:0]                 in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [fpc_width(WE, WF)-1:0]   out_data;
    logic                           out_flush;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flush
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flush
    );
endinterface

// File: rtl/ieee_to_flopoco_conv_fp_pipe_stage.sv
// Single valid/ready register slice; ready looks through to the next stage so a
// full pipeline still moves one word per cycle.
module fp_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    assign ready_o = !valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end
endmodule

// File: rtl/ieee_to_flopoco_conv.sv
// Two-stage streaming converter from IEEE minifloat to FloPoCo {exc, s, e, f},
// with saturating counters of NaN inputs and flushed subnormals.
module ieee_to_flopoco_conv import flopoco_pkg::*; #(
    parameter int WE    = 3,
    parameter int WF    = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ieee_to_flopoco_conv_if.slave bus,
    input  logic                 clr_stats,
    output logic [CNT_W-1:0]     nan_count,
    output logic [CNT_W-1:0]     flush_count
);
    localparam int OW  = fpc_width(WE, WF);
    localparam int S1W = 3 + 1 + WE + WF;
    localparam int S2W = OW + 1;
    localparam logic [WE-1:0] EXP_ONES = '1;

    logic            in_sign;
    logic [WE-1:0]   in_exp;
    logic [WF-1:0]   in_frac;
    fp_class_t       in_class;
    logic            in_xfer;

    assign {in_sign, in_exp, in_frac} = bus.in_data;
    assign in_xfer = bus.in_valid & bus.in_ready;

    always_comb begin
        in_class = NORMAL;
        if (in_exp == '0) begin
            if (in_frac == '0)         in_class = ZERO;
            else if (in_frac[WF-1])    in_class = SUBN;
            else                       in_class = FLUSH;
        end else if (in_exp == EXP_ONES) begin
            in_class = (in_frac == '0) ? INF : NAN;
        end
    end

    logic           s1_valid;
    logic           s2_ready;
    logic [S1W-1:0] s1_q;
    fp_class_t      s1_class;
    logic           s1_sign;
    logic [WE-1:0]  s1_exp;
    logic [WF-1:0]  s1_frac;

    fp_pipe_stage #(.W(S1W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (bus.in_valid),
        .ready_o (bus.in_ready),
        .data_i  ({in_class, in_sign, in_exp, in_frac}),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_q)
    );

    assign s1_class = fp_class_t'(s1_q[S1W-1 -: 3]);
    assign {s1_sign, s1_exp, s1_frac} = s1_q[S1W-4:0];

    logic [1:0]    pk_exc;
    logic          pk_sign;
    logic [WE-1:0] pk_exp;
    logic [WF-1:0] pk_frac;
    logic          pk_flush;

    // A subnormal with the top fraction bit set is 2^-bias * (1.f'), i.e. the
    // smallest FloPoCo binade with the leading one shifted out.
    always_comb begin
        pk_exc   = EXC_ZERO;
        pk_sign  = s1_sign;
        pk_exp   = '0;
        pk_frac  = '0;
        pk_flush = 1'b0;
        case (s1_class)
            NORMAL: begin
                pk_exc  = EXC_NORMAL;
                pk_exp  = s1_exp;
                pk_frac = s1_frac;
            end
            SUBN: begin
                pk_exc  = EXC_NORMAL;
                pk_frac = {s1_frac[WF-2:0], 1'b0};
            end
            FLUSH:   pk_flush = 1'b1;
            INF:     pk_exc   = EXC_INF;
            NAN: begin
                pk_exc  = EXC_NAN;
                pk_sign = 1'b0;
            end
            default: ;
        endcase
    end

    logic [S2W-1:0] s2_q;

    fp_pipe_stage #(.W(S2W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  ({pk_flush, pk_exc, pk_sign, pk_exp, pk_frac}),
        .valid_o (bus.out_valid),
        .ready_i (bus.out_ready),
        .data_o  (s2_q)
    );

    assign {bus.out_flush, bus.out_data} = s2_q;

    logic [CNT_W-1:0] nan_q, nan_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        nan_d   = nan_q;
        flush_d = flush_q;
        if (clr_stats) begin
            nan_d   = '0;
            flush_d = '0;
        end else if (in_xfer) begin
            if (in_class == NAN && nan_q != '1)     nan_d   = nan_q + 1'b1;
            if (in_class == FLUSH && flush_q != '1) flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_q   <= '0;
            flush_q <= '0;
        end else begin
            nan_q   <= nan_d;
            flush_q <= flush_d;
        end
    end

    assign nan_count   = nan_q;
    assign flush_count = flush_q;
endmodule

// File: tb/tb_ieee_to_flopoco_conv.sv
// Bench for ieee_to_flopoco_conv: directed specials, backpressure, throughput,
// counter saturation and mid-run reset, plus randomized traffic against a value model.
module tb_ieee_to_flopoco_conv;
    localparam int WE   = 3;
    localparam int WF   = 3;
    localparam int IW   = 1 + WE + WF;
    localparam int OW   = 3 + WE + WF;
    localparam int EMAX = 2**WE - 1;

    logic clk;
    logic rst_n;
    logic clr_stats;
    logic [15:0] nan_count, flush_count;
    logic [1:0]  nan_count2, flush_count2;

    ieee_to_flopoco_conv_if #(.WE(WE), .WF(WF)) u_if ();
    ieee_to_flopoco_conv_if #(.WE(WE), .WF(WF)) u_if2 ();

    assign u_if2.in_valid  = u_if.in_valid;
    assign u_if2.in_data   = u_if.in_data;
    assign u_if2.out_ready = u_if.out_ready;

    ieee_to_flopoco_conv #(.WE(WE), .WF(WF), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if),
        .clr_stats   (clr_stats),
        .nan_count   (nan_count),
        .flush_count (flush_count)
    );

    ieee_to_flopoco_conv #(.WE(WE), .WF(WF), .CNT_W(2)) u_dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if2),
        .clr_stats   (clr_stats),
        .nan_count   (nan_count2),
        .flush_count (flush_count2)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [OW:0] mk(input int flush, input int exc, input int sgn,
                                       input int ex, input int fr);
        int v = flush * 2**OW + exc * 2**(1+WE+WF) + sgn * 2**(WE+WF) + ex * 2**WF + fr;
        return v[OW:0];
    endfunction

    // Subnormal value is f * 2^(1-bias-WF); FloPoCo's smallest value is 2^-bias
    // (exp 0, frac 0), so it is exact only when f >= 2^(WF-1), frac = 2f - 2^WF.
    function automatic logic [OW:0] model_conv(input logic [IW-1:0] w);
        int s = int'(w[IW-1]);
        int e = int'(w[IW-2:WF]);
        int f = int'(w[WF-1:0]);
        if (e == EMAX) return (f == 0) ? mk(0, 2, s, 0, 0) : mk(0, 3, 0, 0, 0);
        if (e != 0)    return mk(0, 1, s, e, f);
        if (f == 0)    return mk(0, 0, s, 0, 0);
        if (f >= 2**(WF-1)) return mk(0, 1, s, 0, 2*f - 2**WF);
        return mk(1, 0, s, 0, 0);
    endfunction

    function automatic bit model_is_nan(input logic [IW-1:0] w);
        logic [OW:0] r = model_conv(w);
        return r[OW-1:OW-2] == 2'b11;
    endfunction

    function automatic bit model_is_flush(input logic [IW-1:0] w);
        logic [OW:0] r = model_conv(w);
        return r[OW];
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [OW:0] exp_q[$];
    int in_cyc_q[$];
    int out_cyc_q[$];
    int cyc = 0;
    int m_nan = 0, m_flush = 0, m_nan2 = 0, m_flush2 = 0;
    bit prev_stall = 0;
    logic [OW:0] prev_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_nan = 0; m_flush = 0; m_nan2 = 0; m_flush2 = 0;
            prev_stall = 0;
        end else begin
            cyc++;
            check("nan_count",    32'(nan_count),    32'(m_nan));
            check("flush_count",  32'(flush_count),  32'(m_flush));
            check("nan_count2",   32'(nan_count2),   32'(m_nan2));
            check("flush_count2", 32'(flush_count2), 32'(m_flush2));
            if (prev_stall) begin
                check("hold_valid", 32'(u_if.out_valid), 32'd1);
                check("hold_data", 32'({u_if.out_flush, u_if.out_data}), 32'(prev_word));
            end
            if (clr_stats) begin
                m_nan = 0; m_flush = 0; m_nan2 = 0; m_flush2 = 0;
            end else if (u_if.in_valid && u_if.in_ready) begin
                if (model_is_nan(u_if.in_data)) begin
                    if (m_nan < 65535) m_nan++;
                    if (m_nan2 < 3) m_nan2++;
                end
                if (model_is_flush(u_if.in_data)) begin
                    if (m_flush < 65535) m_flush++;
                    if (m_flush2 < 3) m_flush2++;
                end
            end
            if (u_if.in_valid && u_if.in_ready) begin
                exp_q.push_back(model_conv(u_if.in_data));
                in_cyc_q.push_back(cyc);
            end
            if (u_if.out_valid && u_if.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
                else check("out_word", 32'({u_if.out_flush, u_if.out_data}), 32'(exp_q.pop_front()));
                out_cyc_q.push_back(cyc);
            end
            prev_stall = u_if.out_valid && !u_if.out_ready;
            prev_word  = {u_if.out_flush, u_if.out_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [IW-1:0] w);
        bit ok = 0;
        u_if.in_valid = 1'b1;
        u_if.in_data  = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            ok = u_if.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        u_if.in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_and_check(input logic [IW-1:0] w, input logic [OW-1:0] exp_data,
                                  input logic exp_flush);
        bit seen = 0;
        send_word(w);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (u_if.out_valid) begin
                seen = 1;
                break;
            end
        end
        check("dir_seen", 32'(seen), 32'd1);
        check("dir_data", 32'(u_if.out_data), 32'(exp_data));
        check("dir_flush", 32'(u_if.out_flush), 32'(exp_flush));
        @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] d_in  [10] = '{7'h00, 7'h40, 7'h38, 7'h78, 7'h18, 7'h5D, 7'h37, 7'h04, 7'h02, 7'h3C};
    logic [OW-1:0] d_out [10] = '{9'h000, 9'h040, 9'h100, 9'h140, 9'h098, 9'h0DD, 9'h0B7, 9'h080, 9'h000, 9'h180};
    logic          d_fl  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [IW-1:0] bp    [4]  = '{7'h18, 7'h38, 7'h00, 7'h04};

    // ---------------- main sequence ----------------
    initial begin
        int idx;
        rst_n          = 1'b0;
        clr_stats      = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        check("rst_out_data",  32'(u_if.out_data),  32'd0);
        check("rst_out_flush", 32'(u_if.out_flush), 32'd0);
        check("rst_nan",       32'(nan_count),      32'd0);
        check("rst_flush",     32'(flush_count),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(u_if.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // directed specials, normals, subnormals, NaN
        for (int i = 0; i < 10; i++) begin
            send_and_check(d_in[i], d_out[i], d_fl[i]);
            if (d_in[i] == 7'h02) check("dir_flush_count", 32'(flush_count), 32'd1);
            if (d_in[i] == 7'h3C) check("dir_nan_count", 32'(nan_count), 32'd1);
        end

        // backpressure: 6 stalled cycles while offering 4 words
        u_if.out_ready = 1'b0;
        idx = 0;
        repeat (6) begin
            u_if.in_valid = (idx < 4);
            if (idx < 4) u_if.in_data = bp[idx];
            @(negedge clk);
            if (u_if.in_valid && u_if.in_ready) idx++;
            @(posedge clk);
            #1;
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(u_if.in_ready), 32'd0);
        check("bp_out_valid", 32'(u_if.out_valid), 32'd1);
        u_if.out_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = bp[idx];
            @(negedge clk);
            if (u_if.in_ready) idx++;
            @(posedge clk);
            #1;
        end
        u_if.in_valid = 1'b0;
        check("bp_all_sent", 32'(idx), 32'd4);
        repeat (4) @(posedge clk);
        #1;

        // throughput: 32 back-to-back words
        in_cyc_q.delete();
        out_cyc_q.delete();
        u_if.in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            u_if.in_data = IW'($urandom_range(0, 2**IW - 1));
            @(posedge clk);
            #1;
        end
        u_if.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("tp_in_count", 32'(in_cyc_q.size()), 32'd32);
        check("tp_out_count", 32'(out_cyc_q.size()), 32'd32);
        if (in_cyc_q.size() == 32 && out_cyc_q.size() == 32) begin
            check("tp_in_span", 32'(in_cyc_q[31] - in_cyc_q[0]), 32'd31);
            check("tp_latency", 32'(out_cyc_q[0] - in_cyc_q[0]), 32'd2);
            check("tp_out_span", 32'(out_cyc_q[31] - out_cyc_q[0]), 32'd31);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            u_if.in_valid  = 1'($urandom_range(0, 1));
            u_if.in_data   = IW'($urandom_range(0, 2**IW - 1));
            u_if.out_ready = ($urandom_range(0, 3) != 0);
            clr_stats      = ($urandom_range(0, 31) == 0);
            @(posedge clk);
            #1;
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        clr_stats      = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // saturation on the narrow build, then clear beating a NaN
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        repeat (5) send_word(7'h3C);
        repeat (3) @(posedge clk);
        #1;
        check("sat_nan16", 32'(nan_count), 32'd5);
        check("sat_nan2", 32'(nan_count2), 32'd3);
        clr_stats     = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.in_data  = 7'h7F;
        @(negedge clk);
        check("clr_in_ready", 32'(u_if.in_ready), 32'd1);
        @(posedge clk);
        #1;
        clr_stats     = 1'b0;
        u_if.in_valid = 1'b0;
        check("clr_nan16", 32'(nan_count), 32'd0);
        check("clr_nan2", 32'(nan_count2), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // reset with two words in flight
        u_if.out_ready = 1'b0;
        send_word(7'h3C);
        send_word(7'h02);
        check("pre_rst_nan", 32'(nan_count), 32'd1);
        check("pre_rst_flush", 32'(flush_count), 32'd1);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(u_if.out_valid), 32'd0);
        check("mid_rst_nan", 32'(nan_count), 32'd0);
        check("mid_rst_flush", 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(u_if.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(u_if.out_valid), 32'd0);
        u_if.out_ready = 1'b1;
        send_and_check(7'h18, 9'h098, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
